// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the pipelined ALU: opcode encoding,
// flag bit positions and the per-opcode flag write-mask table.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_XOR    = 3'd2,
        OP_RED    = 3'd3,
        OP_SLL    = 3'd4,
        OP_SRA    = 3'd5,
        OP_ROR    = 3'd6,
        OP_PADDSB = 3'd7
    } alu_op_e;

    // Bit positions inside the {Z,V,N} flag register
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Which flags each opcode is allowed to write, indexed by opcode.
    // Arithmetic writes all three, logic/shift ops write Z only,
    // lane ops (RED/PADDSB) leave the flag register alone.
    localparam logic [7:0][2:0] FLAG_WMASK = {
        3'b000,  // 7 PADDSB
        3'b100,  // 6 ROR
        3'b100,  // 5 SRA
        3'b100,  // 4 SLL
        3'b000,  // 3 RED
        3'b100,  // 2 XOR
        3'b111,  // 1 SUB
        3'b111   // 0 ADD
    };

endpackage

// File: rtl/alu_pipe_lane_sat.sv
// One LANE_W-bit signed adder that clamps to the lane's own signed range.
module alu_pipe_lane_sat #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum
);

    logic [LANE_W:0] ext;

    // Add with one guard bit; a guard/MSB disagreement means the lane overflowed
    always_comb begin
        ext = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        if (ext[LANE_W] != ext[LANE_W-1]) begin
            sum = ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
            sum = ext[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 registers operands/op; stage 2 computes, registers the result
// and updates the architectural {Z,V,N} flags through a per-op write mask.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LANE_W   = 4,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  alu_op_e          in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovfl,
    output logic [2:0]       flags
);

    localparam int NLANES = WIDTH / LANE_W;
    localparam int SH_W   = $clog2(WIDTH);

    logic             s1_v_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    alu_op_e          s1_op_reg;
    logic             s2_v_reg;
    logic [WIDTH-1:0] s2_result_reg;
    logic             s2_ovfl_reg;
    logic [2:0]       flags_reg;

    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] paddsb_res;
    logic [WIDTH:0]   alu_out;
    logic [2:0]       flags_new;
    logic [2:0]       flag_mask;

    // Datapath of stage 2: returns {ovfl, result}
    function automatic logic [WIDTH:0] alu_compute(
        input alu_op_e          op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] lanes
    );
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] red;
        logic [SH_W-1:0]  sh;
        logic             ov;
        ext = '0;
        res = '0;
        red = '0;
        ov  = 1'b0;
        sh  = b[SH_W-1:0];
        case (op)
            OP_ADD, OP_SUB: begin
                if (op == OP_SUB) ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
                else              ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
                ov  = ext[WIDTH] ^ ext[WIDTH-1];
                res = ext[WIDTH-1:0];
                // ext[WIDTH] carries the true sign of the unbounded result
                if (SATURATE != 0 && ov) begin
                    res = ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            OP_XOR: res = a ^ b;
            OP_RED: begin
                for (int i = 0; i < NLANES; i++) begin
                    red = red + WIDTH'($signed(a[i*LANE_W +: LANE_W]))
                              + WIDTH'($signed(b[i*LANE_W +: LANE_W]));
                end
                res = red;
            end
            OP_SLL:    res = a << sh;
            OP_SRA:    res = $signed(a) >>> sh;
            OP_ROR:    res = WIDTH'({a, a} >> sh);
            OP_PADDSB: res = lanes;
            default:   res = '0;
        endcase
        return {ov, res};
    endfunction

    // One saturating adder per lane for PADDSB
    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            alu_pipe_lane_sat #(.LANE_W(LANE_W)) u_lane_sat (
                .a   (s1_a_reg[gi*LANE_W +: LANE_W]),
                .b   (s1_b_reg[gi*LANE_W +: LANE_W]),
                .sum (paddsb_res[gi*LANE_W +: LANE_W])
            );
        end
    endgenerate

    // Handshake: a stage advances when it is empty or its successor advances
    always_comb begin
        adv2     = !s2_v_reg || out_ready;
        adv1     = !s1_v_reg || adv2;
        in_ready = adv1 && !flush;
    end

    // Stage-2 result and candidate flag values
    always_comb begin
        alu_out           = alu_compute(s1_op_reg, s1_a_reg, s1_b_reg, paddsb_res);
        flags_new         = '0;
        flags_new[FLAG_Z] = (alu_out[WIDTH-1:0] == '0);
        flags_new[FLAG_V] = alu_out[WIDTH];
        flags_new[FLAG_N] = alu_out[WIDTH-1];
        flag_mask         = FLAG_WMASK[s1_op_reg];
    end

    // Stage 1: capture operands on accept, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg  <= 1'b0;
            s1_a_reg  <= '0;
            s1_b_reg  <= '0;
            s1_op_reg <= OP_ADD;
        end else if (flush) begin
            s1_v_reg <= 1'b0;
        end else if (adv1) begin
            s1_v_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg  <= in_a;
                s1_b_reg  <= in_b;
                s1_op_reg <= in_op;
            end
        end
    end

    // Stage 2: register result; flags change only when a result loads here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg      <= 1'b0;
            s2_result_reg <= '0;
            s2_ovfl_reg   <= 1'b0;
            flags_reg     <= 3'b000;
        end else if (flush) begin
            s2_v_reg <= 1'b0;
        end else if (adv2) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                s2_result_reg <= alu_out[WIDTH-1:0];
                s2_ovfl_reg   <= alu_out[WIDTH];
                flags_reg     <= (flags_reg & ~flag_mask) | (flags_new & flag_mask);
            end
        end
    end

    assign out_valid  = s2_v_reg;
    assign out_result = s2_result_reg;
    assign out_ovfl   = s2_ovfl_reg;
    assign flags      = flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16, LANE_W=4, SATURATE=1): directed steps plus
// random traffic, checked against an arithmetic reference model and a
// queue of in-flight operations.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    alu_op_e     in_op = OP_ADD;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_ovfl;
    logic [2:0]  flags;

    typedef struct {
        alu_op_e     op;
        logic [15:0] res;
        logic        ov;
        logic [2:0]  fl;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [2:0] flags_cur = 3'b000;   // flags after the last op that left the pipe
    logic [2:0] flags_tail = 3'b000;  // flags after the youngest accepted op
    int         edge_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         txns = 0;
    bit         last_acc = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    alu_pipe #(.WIDTH(16), .LANE_W(4), .SATURATE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovfl   (out_ovfl),
        .flags      (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int lane(input logic [15:0] v, input int i);
        logic signed [3:0] n;
        n = v[4*i +: 4];
        return int'(n);
    endfunction

    // Reference model in plain integer arithmetic
    task automatic model(input alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic ov);
        int          s;
        int          sa;
        int          sb;
        int          sh;
        longint      p;
        logic [15:0] t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        ov = 1'b0;
        r  = '0;
        t  = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                s  = (op == OP_ADD) ? sa + sb : sa - sb;
                ov = (s > 32767) || (s < -32768);
                if (s > 32767)       r = 16'h7FFF;
                else if (s < -32768) r = 16'h8000;
                else                 r = s[15:0];
            end
            OP_XOR: r = a ^ b;
            OP_RED: begin
                s = 0;
                for (int i = 0; i < 4; i++) s += lane(a, i) + lane(b, i);
                r = s[15:0];
            end
            OP_SLL: begin
                p = longint'(a) * (longint'(1) << sh);
                r = p[15:0];
            end
            OP_SRA: begin
                s = sa >>> sh;
                r = s[15:0];
            end
            OP_ROR: begin
                t = a;
                repeat (sh) t = {t[0], t[15:1]};
                r = t;
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    s = lane(a, i) + lane(b, i);
                    if (s > 7)  s = 7;
                    if (s < -8) s = -8;
                    t[4*i +: 4] = s[3:0];
                end
                r = t;
            end
        endcase
    endtask

    function automatic logic [2:0] upd(input alu_op_e op, input logic [15:0] r,
                                       input logic ov, input logic [2:0] f);
        case (op)
            OP_ADD, OP_SUB:                 return {(r == 16'd0), ov, r[15]};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: return {(r == 16'd0), f[1], f[0]};
            default:                        return f;
        endcase
    endfunction

    // One clock cycle: check outputs against the model, then advance it
    task automatic step();
        bit          ev;
        bit          er;
        exp_t        e;
        logic [15:0] r;
        logic        ov;
        #1;
        ev = (q.size() > 0) && (q[0].acc <= edge_cnt - 1);
        er = !flush && !(q.size() == 2 && !out_ready);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("out_result", out_result, q[0].res);
            chk("out_ovfl", out_ovfl, q[0].ov);
            chk("flags_busy", flags, q[0].fl);
        end else begin
            chk("flags_idle", flags, flags_cur);
        end
        chk("in_ready", in_ready, er);
        last_acc = 1'b0;
        if (flush) begin
            if (ev) flags_cur = q[0].fl;
            flags_tail = flags_cur;
            q.delete();
        end else begin
            if (ev && out_ready) begin
                txns++;
                $display("txn %0d op=%0d result=%h ovfl=%b flags=%b",
                         txns, q[0].op, out_result, out_ovfl, flags);
                flags_cur = q[0].fl;
                void'(q.pop_front());
            end
            if (in_valid && er) begin
                model(in_op, in_a, in_b, r, ov);
                e.op  = in_op;
                e.res = r;
                e.ov  = ov;
                e.fl  = upd(in_op, r, ov, flags_tail);
                e.acc = edge_cnt + 1;
                flags_tail = e.fl;
                q.push_back(e);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rand_inputs();
        in_op = alu_op_e'(3'($urandom_range(0, 7)));
        in_a  = 16'($urandom);
        in_b  = 16'($urandom);
    endtask

    initial begin
        int sent;
        int cyc;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 16'h0000);
        chk("rst_out_ovfl", out_ovfl, 1'b0);
        chk("rst_flags", flags, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturating ADD and zero SUB
        send(OP_ADD, 16'h7FFF, 16'h0001);
        send(OP_SUB, 16'h0005, 16'h0005);
        chk("t1_add_res", out_result, 16'h7FFF);
        chk("t1_add_ovfl", out_ovfl, 1'b1);
        chk("t1_add_flags", flags, 3'b010);
        idle(1);
        chk("t1_sub_res", out_result, 16'h0000);
        chk("t1_sub_flags", flags, 3'b100);

        // Lane ops leave flags untouched
        send(OP_PADDSB, 16'h7654, 16'h1111);
        send(OP_RED, 16'h1234, 16'h1111);
        chk("t2_paddsb_res", out_result, 16'h7765);
        chk("t2_paddsb_flags", flags, 3'b100);
        idle(1);
        chk("t2_red_res", out_result, 16'h000E);
        chk("t2_red_flags", flags, 3'b100);

        // Shifts and rotates; Z only on a zero result
        send(OP_ROR, 16'h8001, 16'h0001);
        send(OP_SRA, 16'h8000, 16'h000F);
        chk("t3_ror_res", out_result, 16'hC000);
        chk("t3_ror_flags", flags, 3'b000);
        send(OP_SLL, 16'hA5A5, 16'h0000);
        chk("t3_sra_res", out_result, 16'hFFFF);
        send(OP_XOR, 16'h1234, 16'h1234);
        chk("t3_sll_res", out_result, 16'hA5A5);
        chk("t3_sll_flags", flags, 3'b000);
        idle(1);
        chk("t3_xor_res", out_result, 16'h0000);
        chk("t3_xor_flags", flags, 3'b100);
        idle(2);

        // Stream 8 ops with out_ready toggling 1,0,1,0...
        sent = 0;
        cyc  = 0;
        rand_inputs();
        while (sent < 8 && cyc < 200) begin
            in_valid  = 1'b1;
            out_ready = (cyc % 2 == 0);
            step();
            if (last_acc) begin
                sent++;
                rand_inputs();
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        assert (sent == 8) else begin
            errors++;
            $error("FAIL t4_stream_timeout observed=%0d expected=8", sent);
        end
        idle(4);

        // Flush with both stages full and a new op offered
        out_ready = 1'b0;
        send(OP_ADD, 16'h0001, 16'h0001);
        send(OP_XOR, 16'h0005, 16'h0005);
        in_valid = 1'b1;
        in_op    = OP_SUB;
        in_a     = 16'h0003;
        in_b     = 16'h0003;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_flags", flags, 3'b000);
        out_ready = 1'b1;
        idle(3);

        // Asynchronous reset in the middle of a stream
        repeat (3) begin
            rand_inputs();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_result", out_result, 16'h0000);
        chk("t6_flags", flags, 3'b000);
        chk("t6_in_ready", in_ready, 1'b1);
        q.delete();
        flags_cur  = 3'b000;
        flags_tail = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        send(OP_ADD, 16'h8000, 16'h8000);
        idle(1);
        chk("t6_resume_res", out_result, 16'h8000);
        chk("t6_resume_flags", flags, 3'b011);
        idle(2);

        // Random traffic with stalls and occasional flushes
        repeat (400) begin
            rand_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
